res_mem_arbiter: RTL
====================

// Module: res_mem_arbiter
// PURPOSE
//  Shares the single-port result memory (res_* interface, 16384 x 8) between two requesters:
//  port 0 = distance-transform pass engine, port 1 = host/readback engine. Round-robin
//  arbitration, one access per cycle, registered memory-side outputs, fixed read latency.
//  Sits between the engines and the res memory in the DT top level.
// PARAMETERS
//  ADDR_W    14   res memory address width
//  DATA_W    8    res memory data width
//  RR_INIT   0    requester that holds priority after reset (0 or 1)
//  MAX_LOCK  64   max consecutive locked grants before forced release (lock feature only)
// PORTS
//  clk       in   1       single clock, all logic on rising edge
//  reset     in   1       asynchronous, active-low reset
//  reqN      in   1       requester N (N=0,1) wants one access this cycle
//  weN       in   1       1 = write, 0 = read; qualified by reqN
//  addrN     in   ADDR_W  access address
//  wdataN    in   DATA_W  write data
//  lockN     in   1       hold grant across consecutive requests (only with RES_ARB_LOCK_EN)
//  gntN      out  1       combinational; reqN&gntN at a rising edge = access accepted
//  rvalidN   out  1       read data for requester N valid on rdata this cycle
//  rdata     out  DATA_W  shared read data, equals res_di
//  res_rd    out  1       memory read strobe (registered)
//  res_wr    out  1       memory write strobe (registered)
//  res_addr  out  ADDR_W  memory address (registered)
//  res_do    out  DATA_W  memory write data (registered)
//  res_di    in   DATA_W  memory read data, valid the cycle after res_rd is sampled
//  busy      out  1       registered; 1 while any access or read return is in flight
// BEHAVIOUR
//  - Reset (reset=0): res_rd=0, res_wr=0, res_addr=0, res_do=0, rvalid0/1=0, busy=0,
//    priority pointer=RR_INIT, lock counter=0. gntN=0 while reset low. Mid-operation
//    reset drops in-flight reads: no rvalid is produced for them.
//  - Arbitration (comb): only one req -> grant it. Both -> grant the priority holder.
//    Neither -> no grant. Exactly one gnt high at most.
//  - Pointer update at edge with an accepted access: priority moves to the other requester
//    (winner becomes lowest). No access -> pointer unchanged.
//  - Accept at edge E0 -> after E0: res_addr/res_do = winner's addr/wdata, res_wr=weN,
//    res_rd=~weN. No accept -> res_rd=res_wr=0, res_addr/res_do hold last value.
//  - Read latency: memory samples at E1; rvalidN=1 for exactly the cycle E1..E2, rdata=res_di.
//    Total 2 cycles from accept edge to data cycle. Back-to-back reads fully pipelined,
//    one result per cycle, returned in accept order, tagged by rvalidN.
//  - Write: completes at E1, no response. Read to an address written the previous
//    accepted cycle returns the new value (memory ordering preserved, no bypass needed).
//  - res_rd and res_wr never both 1. busy = res_rd|res_wr|rvalid0|rvalid1.
//  - reqN without gntN: requester holds req/we/addr/wdata stable until granted.
// CONFIGURATION
//  RES_ARB_LOCK_EN defined: if the last accepted owner has reqN&lockN high, it wins
//   regardless of pointer; a 7-bit counter counts consecutive locked grants; at MAX_LOCK
//   the other requester, if requesting, wins once and counter clears. Counter clears
//   whenever lock is dropped or ownership changes. Pointer updates as normal.
//  RES_ARB_LOCK_EN undefined: lock0/lock1 ports present but ignored; pure round-robin.
// TESTING
//  1 Reset: hold reset=0 3 cycles -> all outputs 0, gnt0=gnt1=0; release, req1 only -> gnt1=1.
//  2 Single read: req0=1,we0=0,addr0=129, res_di model returns 8'h05 -> res_rd=1,res_addr=129
//    one cycle after accept; rvalid0=1, rdata=8'h05 two cycles after accept; rvalid1 stays 0.
//  3 Contention: req0,req1 held high 6 cycles, RR_INIT=0 -> grants 0,1,0,1,0,1; writes to
//    addr 200/201 land in order, res_rd&res_wr never both 1.
//  4 Pipelined reads: req1 reads addr 16255,16254,16253 back-to-back -> rvalid1 high 3
//    consecutive cycles, data in issue order; busy falls 1 cycle after last rvalid.
//  5 Reset mid-read: assert reset the cycle after accept -> no rvalid, res_rd=0 immediately.
//  6 Lock (RES_ARB_LOCK_EN, MAX_LOCK=4): req0+lock0 and req1 held -> grants 0,0,0,0,1,0,...;
//    without macro same stimulus -> strict 0,1,0,1 alternation.

Source files
------------

// File: rtl/res_mem_arbiter_if.sv
// res_mem_arbiter_if: requester ports and result-memory bus shared by res_mem_arbiter.
interface res_mem_arbiter_if #(parameter int ADDR_W = 14, parameter int DATA_W = 8);
   logic              req0, we0, lock0, gnt0, rvalid0;
   logic              req1, we1, lock1, gnt1, rvalid1;
   logic [ADDR_W-1:0] addr0, addr1, res_addr;
   logic [DATA_W-1:0] wdata0, wdata1, rdata, res_do, res_di;
   logic              res_rd, res_wr, busy;
   modport slave (
      input  req0, we0, lock0, addr0, wdata0, req1, we1, lock1, addr1, wdata1, res_di,
      output gnt0, gnt1, rvalid0, rvalid1, rdata, res_rd, res_wr, res_addr, res_do, busy
   );
   modport master (
      output req0, we0, lock0, addr0, wdata0, req1, we1, lock1, addr1, wdata1, res_di,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata, res_rd, res_wr, res_addr, res_do, busy
   );
endinterface

// File: rtl/res_mem_arbiter.sv
// res_mem_arbiter: round-robin arbiter sharing the res memory between two requesters.
// Define RES_ARB_LOCK_EN to let a locked owner keep the grant for up to MAX_LOCK accesses.
module res_mem_arbiter #(
   parameter int ADDR_W   = 14,
   parameter int DATA_W   = 8,
   parameter int RR_INIT  = 0,
   parameter int MAX_LOCK = 64
) (
   input logic               clk,
   input logic               reset,
   res_mem_arbiter_if.slave  bus
);
   logic              ptr, sel, sel_rr, any, we_w, rd_tag;
   logic              rd_q, wr_q, v0_q, v1_q, busy_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] do_q;
   assign any    = bus.req0 | bus.req1;
   assign sel_rr = bus.req1 & (~bus.req0 | ptr);
`ifdef RES_ARB_LOCK_EN
   logic       owner, owner_vld, own_lock, forced, lock_w;
   logic [6:0] lock_cnt;
   assign own_lock = owner_vld & (owner ? bus.req1 & bus.lock1 : bus.req0 & bus.lock0);
   assign forced   = own_lock & (lock_cnt >= 7'(MAX_LOCK)) & (owner ? bus.req0 : bus.req1);
   assign sel      = forced ? ~owner : own_lock ? owner : sel_rr;
   assign lock_w   = sel ? bus.lock1 : bus.lock0;
   // a grant that starts a new locked run counts as the first of that run
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner     <= 1'b0;
         owner_vld <= 1'b0;
         lock_cnt  <= '0;
      end else if (any) begin
         owner     <= sel;
         owner_vld <= 1'b1;
         lock_cnt  <= (forced | ~lock_w) ? '0 :
                      (owner_vld & (sel == owner)) ? lock_cnt + 7'(lock_cnt != '1) : 7'd1;
      end
   end
`else
   logic unused_lock;
   assign unused_lock = bus.lock0 ^ bus.lock1 ^ (MAX_LOCK != 0);
   assign sel         = sel_rr;
`endif
   assign we_w     = sel ? bus.we1 : bus.we0;
   assign bus.gnt0 = reset & any & ~sel;
   assign bus.gnt1 = reset & any & sel;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr    <= 1'(RR_INIT);
         rd_tag <= 1'b0;
         rd_q   <= 1'b0;
         wr_q   <= 1'b0;
         v0_q   <= 1'b0;
         v1_q   <= 1'b0;
         busy_q <= 1'b0;
         addr_q <= '0;
         do_q   <= '0;
      end else begin
         rd_q   <= any & ~we_w;
         wr_q   <= any & we_w;
         v0_q   <= rd_q & ~rd_tag;
         v1_q   <= rd_q & rd_tag;
         busy_q <= any | rd_q;
         if (any) begin
            ptr    <= ~sel;
            rd_tag <= sel;
            addr_q <= sel ? bus.addr1 : bus.addr0;
            do_q   <= sel ? bus.wdata1 : bus.wdata0;
         end
      end
   end
   assign bus.res_rd   = rd_q;
   assign bus.res_wr   = wr_q;
   assign bus.res_addr = addr_q;
   assign bus.res_do   = do_q;
   assign bus.rvalid0  = v0_q;
   assign bus.rvalid1  = v1_q;
   assign bus.busy     = busy_q;
   assign bus.rdata    = bus.res_di;
endmodule
